// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads a combinational imem, queues {pc, instr, fault}.
// Latency: an instruction fetched in cycle N is at the queue head (out_valid) in cycle N+1.
// Backpressure: out_ready low stops popping; fetch stalls with pc held only when the queue is full.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_addr / imem_instr         word index out, instruction back in the same cycle
//   redirect_valid / redirect_pc   PC change from execute; flushes the queue
//   out_valid / out_ready          handshake towards decode
//   out_instr / out_pc / out_fault head entry (NOP in out_instr for faulted fetches)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [31:0]      IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;

  logic [31:0]      pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];
  logic        q_fault [DEPTH];

  logic        pop;
  logic        fetch;
  logic        fault;
  logic [31:0] push_instr;

  // Low address bits of a redirect target are architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr  = {2'b00, pc[31:2]};
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A simultaneous pop frees a slot, so a full queue can still accept a fetch.
  assign fetch      = ~redirect_valid & ((count < FULL_CNT) | pop);
  assign fault      = ({2'b00, pc[31:2]} >= IMEM_LIMIT);
  assign push_instr = fault ? NOP_INSTR : imem_instr;

  // Head is read straight from registered storage.
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];
  assign out_fault = q_fault[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_fault[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      // Flush: a pop this cycle is still a completed handshake on the old head,
      // but nothing queued survives.
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        q_pc[wr_ptr]    <= pc;
        q_instr[wr_ptr] <= push_instr;
        q_fault[wr_ptr] <= fault;
        wr_ptr          <= wr_ptr + PTR_W'(1);
        pc              <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based reference model and a scoreboard.
// Latency: the model predicts each cycle's head/valid; handshakes push expected entries.
// Backpressure: out_ready is randomized; a monitor pops the scoreboard on each DUT handshake.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  logic [31:0] imem [256];

  int total = 0;
  int bad = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mpc = RESET_PC;
  ent_t        exp_q[$];
  bit          exp_vld = 0;
  ent_t        exp_head;
  logic [31:0] exp_addr = '0;
  bit          started = 0;
  bit          prev_rst = 0;
  ent_t        mon_e;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(256), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return garbage; the DUT must substitute a NOP.
  assign imem_instr = (imem_addr < 32'd256) ? imem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model across the coming edge.
  task automatic step(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit   pop;
    bit   fetch;
    ent_t e;
    @(posedge clk);
    #1;
    if (prev_rst) started = 1;
    prev_rst = rst;
    reset = rst;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    exp_vld = (mq.size() != 0);
    if (exp_vld) exp_head = mq[0];
    exp_addr = mpc >> 2;
    pop = exp_vld && rdy;
    if (pop) exp_q.push_back(mq[0]);
    fetch = !rv && ((mq.size() < DEPTH) || pop);
    if (rst) begin
      mq.delete();
      mpc = RESET_PC;
    end else if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        e.pc = mpc;
        e.fault = (mpc >> 2) >= 32'd256;
        e.instr = e.fault ? NOP : imem[mpc[9:2]];
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  // Monitor: compare DUT against model predictions away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      chk("imem_addr", imem_addr, exp_addr);
      if (out_valid && exp_vld) begin
        chk("head_pc", out_pc, exp_head.pc);
        chk("head_instr", out_instr, exp_head.instr);
        chk("head_fault", {31'd0, out_fault}, {31'd0, exp_head.fault});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %h expected no handshake", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_pc", out_pc, mon_e.pc);
          chk("pop_instr", out_instr, mon_e.instr);
          chk("pop_fault", {31'd0, out_fault}, {31'd0, mon_e.fault});
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int          sel;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h00A0_0113;
    imem[2] = 32'h0020_81B3;
    imem[3] = 32'h0000_0013;

    // Reset values
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC >> 2);

    // Streaming with out_ready held high
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

    // Backpressure fills the queue, then release
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // Redirect while queue holds stale entries
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // Misaligned target, end of imem, 32-bit wrap, back-to-back redirects
    step(0, 1, 1, 32'h43);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h3FC);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h100);
    step(0, 1, 1, 32'h200);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      tgt = $urandom_range(0, 400) * 4 + $urandom_range(0, 3);
      if (sel == 0) tgt = 32'h3F0 + $urandom_range(0, 15);
      else if (sel == 1) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), tgt);
    end

    // Reset beats a full queue and a simultaneous redirect
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h80);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
